// File: rtl/video_timing_pkg.sv
// Shared timing presets and sizing helpers for the scanout path.
package video_timing_pkg;

   typedef struct packed {
      int h_active;
      int h_fp;
      int h_sync;
      int h_bp;
      int v_active;
      int v_fp;
      int v_sync;
      int v_bp;
   } timing_t;

   localparam timing_t SVGA_800x600_60 =
      '{800, 40, 128, 88, 600, 1, 4, 23};
   localparam timing_t VGA_640x480_60 =
      '{640, 16, 96, 48, 480, 10, 2, 33};

   function automatic int color_bits(int r, int g, int b);
      return r + g + b;
   endfunction

   function automatic int cnt_width(int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register used to align sync/DE with returned colour.
module sync_delay_line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage [DEPTH];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else if (flush) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[0] <= din;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign dout = stage[DEPTH-1];

endmodule

// File: rtl/video_scanout_controller.sv
// Video timing + scaled framebuffer addressing with latency-aligned outputs.
// Define VIDEO_SCANOUT_TEST_PATTERN_EN to add the test_pattern colour-bar input.
module video_scanout_controller
   import video_timing_pkg::*;
#(
   parameter int H_ACTIVE   = SVGA_800x600_60.h_active,
   parameter int H_FP       = SVGA_800x600_60.h_fp,
   parameter int H_SYNC     = SVGA_800x600_60.h_sync,
   parameter int H_BP       = SVGA_800x600_60.h_bp,
   parameter int V_ACTIVE   = SVGA_800x600_60.v_active,
   parameter int V_FP       = SVGA_800x600_60.v_fp,
   parameter int V_SYNC     = SVGA_800x600_60.v_sync,
   parameter int V_BP       = SVGA_800x600_60.v_bp,
   parameter int SCALE_X    = 2,
   parameter int SCALE_Y    = 2,
   parameter int RD_LATENCY = 3,
   parameter bit HS_POL     = 1'b1,
   parameter bit VS_POL     = 1'b1,
   parameter int RED_BITS   = 4,
   parameter int GREEN_BITS = 4,
   parameter int BLUE_BITS  = 4
) (
   input  logic clk,
   input  logic resetn,
   input  logic enable,
`ifdef VIDEO_SCANOUT_TEST_PATTERN_EN
   input  logic test_pattern,
`endif
   output logic [cnt_width(H_ACTIVE/SCALE_X)-1:0] fb_rd_x,
   output logic [cnt_width(V_ACTIVE/SCALE_Y)-1:0] fb_rd_y,
   output logic fb_rd_en,
   input  logic [color_bits(RED_BITS, GREEN_BITS, BLUE_BITS)-1:0] color,
   output logic vga_hs,
   output logic vga_vs,
   output logic vga_de,
   output logic [RED_BITS-1:0]   vga_r,
   output logic [GREEN_BITS-1:0] vga_g,
   output logic [BLUE_BITS-1:0]  vga_b,
   output logic frame_start,
   output logic vblank
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW  = cnt_width(H_TOTAL);
   localparam int VW  = cnt_width(V_TOTAL);
   localparam int XW  = cnt_width(H_ACTIVE / SCALE_X);
   localparam int YW  = cnt_width(V_ACTIVE / SCALE_Y);
   localparam int SXW = cnt_width(SCALE_X);
   localparam int SYW = cnt_width(SCALE_Y);
   localparam int CB  = color_bits(RED_BITS, GREEN_BITS, BLUE_BITS);

   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [SXW-1:0] SX_LAST = SXW'(SCALE_X - 1);
   localparam logic [SYW-1:0] SY_LAST = SYW'(SCALE_Y - 1);

   if (SCALE_X < 1 || SCALE_Y < 1) begin : g_bad_scale
      $error("SCALE_X and SCALE_Y must be >= 1");
   end
   if (H_ACTIVE % SCALE_X != 0 || V_ACTIVE % SCALE_Y != 0) begin : g_bad_div
      $error("active size must be a multiple of the scale factor");
   end
   if (RD_LATENCY < 1) begin : g_bad_lat
      $error("RD_LATENCY must be >= 1");
   end
   if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
       V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_porch
      $error("porch and sync widths must be non-zero");
   end

   logic          run;
   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic [SXW-1:0] sx;
   logic [SYW-1:0] sy;
   logic [XW-1:0] x_cnt;
   logic [YW-1:0] y_cnt;

   logic h_act, v_act, h_last, v_last;
   logic active, hs_raw, vs_raw;

   assign h_act  = h_cnt < H_ACT;
   assign v_act  = v_cnt < V_ACT;
   assign h_last = h_cnt == H_LAST;
   assign v_last = v_cnt == V_LAST;
   assign active = run && h_act && v_act;
   assign hs_raw = run && h_cnt >= HS_BEG && h_cnt < HS_END;
   assign vs_raw = run && v_cnt >= VS_BEG && v_cnt < VS_END;

   assign fb_rd_en    = active;
   assign fb_rd_x     = active ? x_cnt : '0;
   assign fb_rd_y     = active ? y_cnt : '0;
   assign frame_start = run && h_cnt == '0 && v_cnt == '0;
   assign vblank      = !run || !v_act;

   // Stop is only honoured on the last clock of a frame.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         run   <= 1'b0;
         h_cnt <= '0;
         v_cnt <= '0;
         sx    <= '0;
         sy    <= '0;
         x_cnt <= '0;
         y_cnt <= '0;
      end else if (!run) begin
         run   <= enable;
         h_cnt <= '0;
         v_cnt <= '0;
         sx    <= '0;
         sy    <= '0;
         x_cnt <= '0;
         y_cnt <= '0;
      end else if (h_last) begin
         h_cnt <= '0;
         sx    <= '0;
         x_cnt <= '0;
         if (v_last) begin
            v_cnt <= '0;
            sy    <= '0;
            y_cnt <= '0;
            run   <= enable;
         end else begin
            v_cnt <= v_cnt + 1'b1;
            if (v_act) begin
               if (sy == SY_LAST) begin
                  sy    <= '0;
                  y_cnt <= y_cnt + 1'b1;
               end else begin
                  sy <= sy + 1'b1;
               end
            end
         end
      end else begin
         h_cnt <= h_cnt + 1'b1;
         if (active) begin
            if (sx == SX_LAST) begin
               sx    <= '0;
               x_cnt <= x_cnt + 1'b1;
            end else begin
               sx <= sx + 1'b1;
            end
         end
      end
   end

   logic d_act, d_hs, d_vs;

`ifdef VIDEO_SCANOUT_TEST_PATTERN_EN
   localparam int DW = 3 + XW;
   logic [XW-1:0] d_x;
   logic [2:0]    bar;
   logic [DW-1:0] d_in, d_out;
   assign d_in = {active, hs_raw, vs_raw, fb_rd_x};
   assign {d_act, d_hs, d_vs, d_x} = d_out;
   if (XW >= 3) begin : g_bar_msb
      assign bar = d_x[XW-1 -: 3];
   end else begin : g_bar_ext
      assign bar = 3'(d_x);
   end
`else
   localparam int DW = 3;
   logic [DW-1:0] d_in, d_out;
   assign d_in = {active, hs_raw, vs_raw};
   assign {d_act, d_hs, d_vs} = d_out;
`endif

   // Inputs are already inactive while stopped, so the line drains itself.
   sync_delay_line #(
      .WIDTH (DW),
      .DEPTH (RD_LATENCY)
   ) u_dly (
      .clk    (clk),
      .resetn (resetn),
      .flush  (1'b0),
      .din    (d_in),
      .dout   (d_out)
   );

   logic [RED_BITS-1:0]   pix_r;
   logic [GREEN_BITS-1:0] pix_g;
   logic [BLUE_BITS-1:0]  pix_b;

   always_comb begin
      pix_r = color[CB-1 -: RED_BITS];
      pix_g = color[BLUE_BITS +: GREEN_BITS];
      pix_b = color[0 +: BLUE_BITS];
`ifdef VIDEO_SCANOUT_TEST_PATTERN_EN
      if (test_pattern) begin
         pix_r = {RED_BITS{bar[2]}};
         pix_g = {GREEN_BITS{bar[1]}};
         pix_b = {BLUE_BITS{bar[0]}};
      end
`endif
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         vga_hs <= ~HS_POL;
         vga_vs <= ~VS_POL;
         vga_de <= 1'b0;
         vga_r  <= '0;
         vga_g  <= '0;
         vga_b  <= '0;
      end else begin
         vga_hs <= d_hs ? HS_POL : ~HS_POL;
         vga_vs <= d_vs ? VS_POL : ~VS_POL;
         vga_de <= d_act;
         vga_r  <= d_act ? pix_r : '0;
         vga_g  <= d_act ? pix_g : '0;
         vga_b  <= d_act ? pix_b : '0;
      end
   end

endmodule

// File: tb/tb_video_scanout_controller.sv
// Directed bench: small 14x8 timing, unscaled and 2x2-scaled instances.
module tb_video_scanout_controller;

   localparam int HT  = 14;
   localparam int VT  = 8;
   localparam int LAT = 4;

   logic clk = 1'b0;
   logic resetn;
   logic enable;
   logic tp = 1'b0;

   logic [2:0]  a_x;
   logic [1:0]  a_y;
   logic        a_en, a_hs, a_vs, a_de, a_fs, a_vb;
   logic [3:0]  a_r, a_g, a_b;
   logic [11:0] a_color, ca1, ca2, ca3;

   logic [1:0]  b_x;
   logic [0:0]  b_y;
   logic        b_en, b_hs, b_vs, b_de, b_fs, b_vb;
   logic [3:0]  b_r, b_g, b_b;
   logic [11:0] b_color, cb1, cb2, cb3;

   int n_vec   = 0;
   int n_bad   = 0;
   int run_end = 336;
   int cur_k   = 0;

   always #5 clk = ~clk;

   video_scanout_controller #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .SCALE_X(1), .SCALE_Y(1), .RD_LATENCY(3)
   ) u_a (
      .clk(clk), .resetn(resetn), .enable(enable),
`ifdef VIDEO_SCANOUT_TEST_PATTERN_EN
      .test_pattern(tp),
`endif
      .fb_rd_x(a_x), .fb_rd_y(a_y), .fb_rd_en(a_en),
      .color(a_color), .vga_hs(a_hs), .vga_vs(a_vs),
      .vga_de(a_de), .vga_r(a_r), .vga_g(a_g), .vga_b(a_b),
      .frame_start(a_fs), .vblank(a_vb)
   );

   video_scanout_controller #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .SCALE_X(2), .SCALE_Y(2), .RD_LATENCY(3)
   ) u_b (
      .clk(clk), .resetn(resetn), .enable(enable),
`ifdef VIDEO_SCANOUT_TEST_PATTERN_EN
      .test_pattern(tp),
`endif
      .fb_rd_x(b_x), .fb_rd_y(b_y), .fb_rd_en(b_en),
      .color(b_color), .vga_hs(b_hs), .vga_vs(b_vs),
      .vga_de(b_de), .vga_r(b_r), .vga_g(b_g), .vga_b(b_b),
      .frame_start(b_fs), .vblank(b_vb)
   );

   function automatic logic [11:0] mem_px(int x);
      return {4'(x + 1), 4'(x * 3), 4'(~x)};
   endfunction

   function automatic logic [11:0] bar_px(int x);
      logic [2:0] i;
      i = 3'(x);
      return {{4{i[2]}}, {4{i[1]}}, {4{i[0]}}};
   endfunction

   // Framebuffer/palette stand-in: colour returns three clocks after the request.
   always @(posedge clk) begin
      ca1 <= mem_px(int'(a_x));
      ca2 <= ca1;
      ca3 <= ca2;
      cb1 <= mem_px(int'(b_x));
      cb2 <= cb1;
      cb3 <= cb2;
   end
   assign a_color = ca3;
   assign b_color = cb3;

   task automatic check(string tag, int got, int exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s k=%0d got=%0h exp=%0h", tag, cur_k, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic on_at(int k);
      return k >= 0 && k < run_end;
   endfunction

   function automatic logic act_at(int k);
      return on_at(k) && (k % HT) < 8 && ((k / HT) % VT) < 4;
   endfunction

   task automatic check_cycle(int k);
      int h, v, hd, vd;
      logic a, ad, hs, vs, fs, vb;
      logic [11:0] pa, pb;
      h  = k % HT;
      v  = (k / HT) % VT;
      hd = (k - LAT) % HT;
      vd = ((k - LAT) / HT) % VT;
      a  = act_at(k);
      ad = act_at(k - LAT);
      hs = on_at(k - LAT) && hd >= 10 && hd < 13;
      vs = on_at(k - LAT) && vd >= 5 && vd < 7;
      fs = on_at(k) && (k % (HT * VT)) == 0;
      vb = !on_at(k) || v >= 4;
      pa = !ad ? 12'h0 : tp ? bar_px(hd) : mem_px(hd);
      pb = !ad ? 12'h0 : tp ? bar_px(hd / 2) : mem_px(hd / 2);
      cur_k = k;
      check("a_en", a_en, a);
      check("b_en", b_en, a);
      check("a_x", a_x, a ? h : 0);
      check("a_y", a_y, a ? v : 0);
      check("b_x", b_x, a ? h / 2 : 0);
      check("b_y", b_y, a ? v / 2 : 0);
      check("a_fs", a_fs, fs);
      check("b_fs", b_fs, fs);
      check("a_vb", a_vb, vb);
      check("b_vb", b_vb, vb);
      check("a_hs", a_hs, hs);
      check("b_hs", b_hs, hs);
      check("a_vs", a_vs, vs);
      check("b_vs", b_vs, vs);
      check("a_de", a_de, ad);
      check("b_de", b_de, ad);
      check("a_rgb", {a_r, a_g, a_b}, pa);
      check("b_rgb", {b_r, b_g, b_b}, pb);
   endtask

   task automatic check_reset();
      check("rst_hs", a_hs, 0);
      check("rst_vs", a_vs, 0);
      check("rst_de", a_de, 0);
      check("rst_rgb", {a_r, a_g, a_b}, 0);
      check("rst_en", a_en, 0);
      check("rst_x", a_x, 0);
      check("rst_fs", a_fs, 0);
      check("rst_vb", a_vb, 1);
      check("rst_b_de", b_de, 0);
      check("rst_b_vb", b_vb, 1);
   endtask

   initial begin
      resetn = 1'b1;
      enable = 1'b0;
      #1 resetn = 1'b0;
      #1 check_reset();
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      repeat (3) step();
      cur_k = -1;
      check("stop_vb", a_vb, 1);
      check("stop_en", a_en, 0);
      check("stop_fs", a_fs, 0);
      check("stop_hs", a_hs, 0);
      enable = 1'b1;
      step();
      // Frame 2 drops and restores enable; frame 3 drops it for good.
      for (int k = 0; k < 346; k++) begin
         check_cycle(k);
         if (k == 140) enable = 1'b0;
         if (k == 182) enable = 1'b1;
         if (k == 252) enable = 1'b0;
         if (k == 345) begin
            enable = 1'b1;
`ifdef VIDEO_SCANOUT_TEST_PATTERN_EN
            tp = 1'b1;
`endif
         end
         step();
      end
      run_end = 1000000;
      for (int k = 0; k < 21; k++) begin
         check_cycle(k);
         if (k < 20) step();
      end
      resetn = 1'b0;
      #1 check_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/video_scanout_controller.md
Name: video_scanout_controller

Overview:
Parametrised successor to the fixed 800x600 VGA video controller. Generates programmable-at-elaboration video timing and integer pixel-replication (scaling) read coordinates for the framebuffer/palette path. Delays sync and data-enable by a configurable read latency so they stay aligned with returned colour. Sits in the vga_clk domain between Framebuffer/Palette and the VGA pins; exposes frame_start/vblank status for display-processor buffer swaps.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FP, 40, horizontal front porch (clocks)
H_SYNC, 128, horizontal sync width
H_BP, 88, horizontal back porch
V_ACTIVE, 600, visible lines
V_FP, 1, vertical front porch (lines)
V_SYNC, 4, vertical sync width
V_BP, 23, vertical back porch
SCALE_X, 2, horizontal pixel replication factor (>=1)
SCALE_Y, 2, vertical line replication factor (>=1)
RD_LATENCY, 3, clocks from fb_rd_x/y to valid color input (>=1)
HS_POL, 1, active level of vga_hs
VS_POL, 1, active level of vga_vs
RED_BITS / GREEN_BITS / BLUE_BITS, 4 / 4 / 4, channel widths; COLOR_BITS = sum

Ports:
clk  in  1  pixel clock (vga_clk)
resetn  in  1  asynchronous active-low reset
enable  in  1  scanout run request
fb_rd_x  out  $clog2(H_ACTIVE/SCALE_X)  framebuffer column request
fb_rd_y  out  $clog2(V_ACTIVE/SCALE_Y)  framebuffer row request
fb_rd_en  out  1  request valid (active region)
color  in  COLOR_BITS  palette colour, RD_LATENCY after request; {R,G,B} MSB-first
vga_hs  out  1  horizontal sync
vga_vs  out  1  vertical sync
vga_de  out  1  data enable, aligned with vga_r/g/b
vga_r / vga_g / vga_b  out  RED_BITS / GREEN_BITS / BLUE_BITS  pixel output
frame_start  out  1  one-clock pulse at request-stage (h=0,v=0) while running
vblank  out  1  request-stage level: v_cnt >= V_ACTIVE, or stopped

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. h_cnt 0..H_TOTAL-1 wraps to 0 and advances v_cnt; v_cnt wraps at V_TOTAL-1.
- Request stage (cycle 0): active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE; hs_raw when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; vs_raw analogous on v_cnt.
- Scaling via sub-counters, no dividers: sx 0..SCALE_X-1 steps during active; on wrap fb_rd_x++. sx, fb_rd_x cleared at h_cnt=H_TOTAL-1. sy steps at each line end while v_cnt<V_ACTIVE; on wrap fb_rd_y++; sy, fb_rd_y cleared at frame end. fb_rd_x/y hold 0 outside active rows/cols; fb_rd_en = active.
- Output stage: active, hs_raw, vs_raw pass through RD_LATENCY-deep shift register; outputs registered. vga_de = delayed active; vga_r/g/b = color fields when vga_de else 0. vga_hs = delayed hs_raw ? HS_POL : ~HS_POL; same for vs.
- Run control: run register. Stopped: counters held 0, fb_rd_en=0, delay line flushed with inactive, vblank=1. enable high while stopped -> run=1 next clock, counting starts at (0,0), frame_start pulses that cycle. enable low while running -> stop only at frame end (h=H_TOTAL-1, v=V_TOTAL-1); frames never truncated. enable re-asserted before frame end cancels stop.
- Reset (async assert, sync deassert by caller): counters/sub-counters 0, run=0, delay line inactive, vga_hs=~HS_POL, vga_vs=~VS_POL, vga_de=0, rgb=0, fb_rd_*=0, frame_start=0, vblank=1. Reset mid-frame discards frame.
- Elaboration $error if H_ACTIVE%SCALE_X!=0, V_ACTIVE%SCALE_Y!=0, RD_LATENCY<1, or any porch/sync = 0.

Optional Feature:
VIDEO_SCANOUT_TEST_PATTERN_EN: defined -> extra input test_pattern (1 bit); when high, output colour replaced by 8 vertical bars from delayed fb_rd_x top 3 bits (bar i: R=i[2],G=i[1],B=i[0] replicated to full channel), ignoring color; timing unchanged. Undefined -> port absent, color always used.

Decomposition:
- Package video_timing_pkg: timing-parameter struct typedef, preset constants (SVGA_800x600_60, VGA_640x480_60), COLOR_BITS helper functions.
- Sub-module sync_delay_line (parametric width/depth shift register with async reset and flush) for active/hs/vs alignment.

Test Plan:
- Reset: resetn=0 mid-line -> all outputs at reset values immediately; vga_hs=0 with HS_POL=1.
- Small timing (H 8/2/3/1, V 4/1/2/1, SCALE 1, RD_LATENCY 3): vga_hs high for h_cnt 10..12 delayed 3 clocks; line = 14 clocks; frame = 112 clocks; frame_start every 112.
- Scaling SCALE_X=2, SCALE_Y=2, H_ACTIVE=8: fb_rd_x per line 0,0,1,1,2,2,3,3; fb_rd_y per line 0,0,1,1.
- Alignment: color = registered function of fb_rd_x delayed 3 -> vga_r/g/b match exactly while vga_de=1, zero when 0.
- Enable drop mid-frame at v=2: frame completes to v=7, stops, vblank=1; re-enable -> frame_start next clock, h=0.
- Test pattern (macro defined, H_ACTIVE=8): test_pattern=1 -> pixel x shows bar x (x=5 -> R max, G=0, B max).
